if_unit: RTL and testbench
==========================

// Module: if_unit
// PURPOSE
//  Instruction-fetch stage (pre-IF + IF) of the 5-stage LoongArch32 pipeline. It is the producer end of the
//  IF->ID valid/allow-in handshake and the consumer of br_bus driven by the decode stage.
//  Generates nextpc and drives the synchronous inst SRAM (1-cycle read latency). Delivers {pc, inst} to ID.
//  Cancels the in-flight fetch and redirects on a taken branch.
// PARAMETERS (constants from shared header my_cpu.vh)
//  IF_to_ID_Bus_Size  64           {pc[63:32], inst[31:0]}
//  br_bus_Size        34           {br_taken[33], br_target[32:1], stall[0]}
//  RESET_PC           32'h1c000000 first fetched address after reset
// PORTS
//  clk              in   1   clock
//  reset            in   1   synchronous, active-high
//  ID_Allow_in      in   1   ID can accept a new instruction this cycle
//  br_bus           in   34  branch redirect from ID; stall bit [0] ignored by this block
//  IF_to_ID_Valid   out  1   IF holds a valid instruction for ID
//  IF_to_ID_Bus     out  64  {pc, inst}
//  inst_sram_en     out  1   read enable
//  inst_sram_we     out  4   constant 4'b0000
//  inst_sram_addr   out  32  fetch address
//  inst_sram_wdata  out  32  constant 32'b0
//  inst_sram_rdata  in   32  read data, valid the cycle after en
// BEHAVIOUR
//  - Reset values: IF_Valid=0 (IF_to_ID_Valid=0); IF_pc=RESET_PC-4 (32'h1bfffffc); buf_valid=0; buf=0.
//    During reset, inst_sram_en=0.
//  - Pre-IF:
//    - to_IF_valid = ~reset.
//    - seq_pc = IF_pc + 4, with 32-bit wrap.
//    - nextpc = br_taken ? br_target : seq_pc.
//  - IF_ReadyGo = 1.
//  - IF_Allow_in = ~IF_Valid | (IF_ReadyGo & ID_Allow_in) | br_taken.
//  - Fetch issue: inst_sram_en = to_IF_valid & IF_Allow_in; inst_sram_addr = nextpc. Latency is 1 cycle
//    from issue to IF_to_ID_Valid.
//  - On a cycle with IF_Allow_in:
//    - IF_Valid <= to_IF_valid;
//    - IF_pc <= nextpc.
//  - Redirect: br_taken is honoured in the cycle it is high, even if ID_Allow_in=0.
//    - The IF instruction in that cycle is discarded: IF_to_ID_Valid is still driven, but ID drops it.
//    - br_target is issued the same cycle; the first target instruction is valid the next cycle.
//  - Handshake: ID consumes the instruction when IF_to_ID_Valid & ID_Allow_in. While ID_Allow_in=0,
//    {pc, inst} and IF_to_ID_Valid are held stable.
//  - First cycle after reset deasserts: fetch of RESET_PC is issued; IF_Valid=1 the next cycle.
//  - Reset mid-stall: buffer and IF_Valid are cleared; fetch restarts at RESET_PC.
//  - Addresses are not alignment-checked (ADEF is out of scope); addr[1:0] is passed through unchanged.
// CONFIGURATION
//  IF_INST_BUF_EN defined:
//    - 32-bit inst buffer plus buf_valid.
//    - Capture rule: if IF_Valid & ~ID_Allow_in & ~buf_valid & ~br_taken, then buf <= rdata and buf_valid <= 1.
//    - Clear rule: buf_valid <= 0 on IF_Allow_in or reset.
//    - inst = buf_valid ? buf : inst_sram_rdata.
//    - No SRAM access during a stall.
//  IF_INST_BUF_EN undefined:
//    - No buffer.
//    - While IF_Valid & ~IF_Allow_in: inst_sram_en=1 and inst_sram_addr=IF_pc. The same word is re-read
//      every stall cycle, so rdata stays correct.
//    - inst = inst_sram_rdata always.
// STRUCTURE
//  - my_cpu.vh: bus-size constants and RESET_PC.
//  - Single flat module; no sub-module needed. The optional buffer is inline, guarded by `ifdef.
// TESTING
//  1. Reset release, ID_Allow_in=1: addresses 1c000000, 1c000004, 1c000008 are issued on consecutive cycles.
//     Each appears on IF_to_ID_Bus one cycle later with the matching rdata.
//  2. ID_Allow_in=0 for 3 cycles while holding pc 1c000004 with inst 0x02800421:
//     - bus is stable for all 3 cycles;
//     - resumes at 1c000008 after release;
//     - both macro settings are covered.
//  3. br_taken with target 1c000100 while IF holds 1c000008: 1c000008 never reaches ID; next valid pc is
//     1c000100; then 1c000104 follows.
//  4. br_taken coincident with ID_Allow_in=0: redirect is still taken; the buffer (if present) is cleared;
//     the next valid pc is br_target.
//  5. Reset asserted mid-stall with a full buffer: IF_to_ID_Valid=0 next cycle; fetch restarts at 1c000000.
//  6. IF_pc=32'hfffffffc with a sequential fetch: nextpc wraps to 0.

Source files
------------

// File: rtl/if_unit_pkg.sv
// Shared fetch-stage constants and the IF->ID and branch-bus layouts.
// Used by if_unit and the decode stage.
package if_unit_pkg;

    localparam int IF_TO_ID_BUS_SIZE = 64;
    localparam int BR_BUS_SIZE       = 34;
    localparam logic [31:0] RESET_PC = 32'h1c00_0000;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
        logic        stall;
    } br_bus_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } if_id_t;

endpackage

// File: rtl/if_unit.sv
// Pre-IF + IF fetch stage: nextpc, inst SRAM port, {pc, inst} to ID.
// Optional inst hold buffer enabled by defining IF_INST_BUF_EN.
module if_unit
    import if_unit_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ID_Allow_in,
    input  logic [BR_BUS_SIZE-1:0]       br_bus,
    output logic                         IF_to_ID_Valid,
    output logic [IF_TO_ID_BUS_SIZE-1:0] IF_to_ID_Bus,
    output logic                         inst_sram_en,
    output logic [3:0]                   inst_sram_we,
    output logic [31:0]                  inst_sram_addr,
    output logic [31:0]                  inst_sram_wdata,
    input  logic [31:0]                  inst_sram_rdata
);

    localparam logic IF_READY_GO = 1'b1;

    br_bus_t     br;
    if_id_t      to_id;
    logic        to_if_valid;
    logic        if_valid;
    logic        if_allow_in;
    logic [31:0] if_pc;
    logic [31:0] seq_pc;
    logic [31:0] nextpc;
    logic [31:0] inst;
    logic        unused_stall;

    assign br           = br_bus_t'(br_bus);
    assign unused_stall = br.stall;

    assign to_if_valid = ~reset;
    assign seq_pc      = if_pc + 32'd4;
    assign nextpc      = br.taken ? br.target : seq_pc;
    assign if_allow_in = ~if_valid | (IF_READY_GO & ID_Allow_in)
                       | br.taken;

    always_ff @(posedge clk) begin
        if (reset) begin
            if_valid <= 1'b0;
            if_pc    <= RESET_PC - 32'd4;
        end else if (if_allow_in) begin
            if_valid <= to_if_valid;
            if_pc    <= nextpc;
        end
    end

`ifdef IF_INST_BUF_EN
    logic [31:0] inst_buf;
    logic        buf_valid;

    // Latch the word once on stall entry so the SRAM can idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid <= 1'b0;
            inst_buf  <= 32'b0;
        end else if (if_allow_in) begin
            buf_valid <= 1'b0;
        end else if (if_valid & ~ID_Allow_in & ~buf_valid
                     & ~br.taken) begin
            buf_valid <= 1'b1;
            inst_buf  <= inst_sram_rdata;
        end
    end

    assign inst           = buf_valid ? inst_buf : inst_sram_rdata;
    assign inst_sram_en   = to_if_valid & if_allow_in;
    assign inst_sram_addr = nextpc;
`else
    // No buffer: re-read the held pc each stall cycle.
    assign inst           = inst_sram_rdata;
    assign inst_sram_en   = to_if_valid & (if_allow_in | if_valid);
    assign inst_sram_addr = if_allow_in ? nextpc : if_pc;
`endif

    assign inst_sram_we    = 4'b0000;
    assign inst_sram_wdata = 32'b0;

    assign to_id.pc       = if_pc;
    assign to_id.inst     = inst;
    assign IF_to_ID_Valid = if_valid;
    assign IF_to_ID_Bus   = to_id;

endmodule

// File: tb/tb_if_unit.sv
// Self-checking bench for if_unit: directed vector table plus random
// stimulus checked against a program-order reference model.
module tb_if_unit;
    import if_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ID_Allow_in;
    logic [33:0] br_bus;
    logic        IF_to_ID_Valid;
    logic [63:0] IF_to_ID_Bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata = 32'b0;

    int checks = 0;
    int failures = 0;

    if_unit dut (
        .clk             (clk),
        .reset           (reset),
        .ID_Allow_in     (ID_Allow_in),
        .br_bus          (br_bus),
        .IF_to_ID_Valid  (IF_to_ID_Valid),
        .IF_to_ID_Bus    (IF_to_ID_Bus),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h1c00_0004) return 32'h0280_0421;
        return {a[15:0], a[31:16]} ^ 32'h1357_2468;
    endfunction

    always @(posedge clk)
        if (inst_sram_en) inst_sram_rdata <= mem(inst_sram_addr);

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model state: program order seen by ID
    logic        first = 1'b1;
    logic        prev_rst;
    logic        prev_hold = 1'b0;
    logic [63:0] prev_bus;
    logic [31:0] prog_pc = RESET_PC;

    task automatic observe(input logic rst, input logic allow,
                           input logic br, input logic [31:0] tgt);
        if (!first) chk("valid_model", 64'(IF_to_ID_Valid), 64'(!prev_rst));
        if (prev_hold) chk("hold_stable", IF_to_ID_Bus, prev_bus);
        chk("sram_we_wdata", {28'b0, inst_sram_we, inst_sram_wdata}, 64'b0);
        if (rst) chk("en_in_reset", 64'(inst_sram_en), 64'b0);
        if (!rst && IF_to_ID_Valid && allow && !br) begin
            chk("consume", IF_to_ID_Bus, {prog_pc, mem(prog_pc)});
            prog_pc = prog_pc + 32'd4;
        end
        if (rst) prog_pc = RESET_PC;
        else if (br) prog_pc = tgt;
        prev_hold = !rst && IF_to_ID_Valid && !allow && !br;
        prev_bus  = IF_to_ID_Bus;
        prev_rst  = rst;
        first     = 1'b0;
    endtask

    typedef struct {
        logic        rst;
        logic        allow;
        logic        br;
        logic [31:0] tgt;
        logic        ev;
        logic [31:0] epc;
        int          en_kind;
        logic [31:0] eaddr;
    } vec_t;

    vec_t vt[20];

    function automatic vec_t mk(input logic rst, input logic allow,
                                input logic br, input logic [31:0] tgt,
                                input logic ev, input logic [31:0] epc,
                                input int en_kind, input logic [31:0] ea);
        vec_t v;
        v.rst = rst; v.allow = allow; v.br = br; v.tgt = tgt;
        v.ev = ev; v.epc = epc; v.en_kind = en_kind; v.eaddr = ea;
        return v;
    endfunction

    task automatic drive(input logic rst, input logic allow,
                         input logic br, input logic [31:0] tgt);
        reset       = rst;
        ID_Allow_in = allow;
        br_bus      = {br, tgt, 1'b0};
    endtask

    initial begin
        drive(1'b1, 1'b1, 1'b0, 32'b0);
        // en_kind: 0 = en low, 1 = en at eaddr, 2 = stall cycle
        vt[0]  = mk(1, 1, 0, 0, 0, 0, 0, 0);
        vt[1]  = mk(1, 1, 0, 0, 0, 0, 0, 0);
        vt[2]  = mk(0, 1, 0, 0, 0, 0, 1, 32'h1c000000);
        vt[3]  = mk(0, 1, 0, 0, 1, 32'h1c000000, 1, 32'h1c000004);
        vt[4]  = mk(0, 0, 0, 0, 1, 32'h1c000004, 2, 32'h1c000004);
        vt[5]  = mk(0, 0, 0, 0, 1, 32'h1c000004, 2, 32'h1c000004);
        vt[6]  = mk(0, 0, 0, 0, 1, 32'h1c000004, 2, 32'h1c000004);
        vt[7]  = mk(0, 1, 0, 0, 1, 32'h1c000004, 1, 32'h1c000008);
        vt[8]  = mk(0, 1, 1, 32'h1c000100, 1, 32'h1c000008, 1, 32'h1c000100);
        vt[9]  = mk(0, 1, 0, 0, 1, 32'h1c000100, 1, 32'h1c000104);
        vt[10] = mk(0, 0, 0, 0, 1, 32'h1c000104, 2, 32'h1c000104);
        vt[11] = mk(0, 0, 1, 32'h1c000200, 1, 32'h1c000104, 1, 32'h1c000200);
        vt[12] = mk(0, 1, 0, 0, 1, 32'h1c000200, 1, 32'h1c000204);
        vt[13] = mk(0, 1, 1, 32'hfffffffc, 1, 32'h1c000204, 1, 32'hfffffffc);
        vt[14] = mk(0, 1, 0, 0, 1, 32'hfffffffc, 1, 32'h00000000);
        vt[15] = mk(0, 0, 0, 0, 1, 32'h00000000, 2, 32'h00000000);
        vt[16] = mk(0, 0, 0, 0, 1, 32'h00000000, 2, 32'h00000000);
        vt[17] = mk(1, 0, 0, 0, 1, 32'h00000000, 0, 0);
        vt[18] = mk(0, 0, 0, 0, 0, 0, 1, 32'h1c000000);
        vt[19] = mk(0, 1, 0, 0, 1, 32'h1c000000, 1, 32'h1c000004);

        for (int i = 0; i < 20; i++) begin
            drive(vt[i].rst, vt[i].allow, vt[i].br, vt[i].tgt);
            @(negedge clk);
            chk($sformatf("v%0d_valid", i), 64'(IF_to_ID_Valid), 64'(vt[i].ev));
            if (vt[i].ev)
                chk($sformatf("v%0d_bus", i), IF_to_ID_Bus,
                    {vt[i].epc, mem(vt[i].epc)});
            case (vt[i].en_kind)
                0: chk($sformatf("v%0d_en", i), 64'(inst_sram_en), 64'b0);
                1: chk($sformatf("v%0d_en_addr", i),
                       {31'b0, inst_sram_en, inst_sram_addr},
                       {31'b0, 1'b1, vt[i].eaddr});
                default: begin
`ifdef IF_INST_BUF_EN
                    chk($sformatf("v%0d_stall_en", i), 64'(inst_sram_en), 64'b0);
`else
                    chk($sformatf("v%0d_stall_en_addr", i),
                        {31'b0, inst_sram_en, inst_sram_addr},
                        {31'b0, 1'b1, vt[i].eaddr});
`endif
                end
            endcase
            observe(vt[i].rst, vt[i].allow, vt[i].br, vt[i].tgt);
            @(posedge clk);
            #1;
        end

        for (int n = 0; n < 3000; n++) begin
            logic        r, a, b;
            logic [31:0] t;
            r = ($urandom_range(99) < 3);
            a = ($urandom_range(99) < 60);
            b = ($urandom_range(99) < 15);
            case ($urandom_range(3))
                0: t = 32'hfffffffc;
                1: t = $urandom;
                default: t = RESET_PC + {$urandom_range(1023), 2'b00};
            endcase
            drive(r, a, b, t);
            @(negedge clk);
            observe(r, a, b, t);
            @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
